// File: rtl/elevator_pkg.sv
// Shared types and default timing for the elevator car scheduler.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DWELL     = 2'd3
  } state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam int DEF_NUM_FLOORS   = 8;
  localparam int DEF_TRAVEL_TICKS = 50000000;
  localparam int DEF_DWELL_TICKS  = 30000000;

endpackage

// File: rtl/elevator_tick_timer.sv
// Free-running tick counter: done pulses on the last of every MAX enabled cycles.
// clr has priority over en and forces the count back to zero.
module tick_timer #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int CW = (MAX > 1) ? $clog2(MAX) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign done = en && !clr && (cnt_q == CW'(MAX - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = done ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN scheduler for one car: latches requests, times travel and dwell, drives door_controller.
// Request to motion latency is 2 cycles; all outputs are registered.
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS   = DEF_NUM_FLOORS,
  parameter int FLOOR_W      = 3,
  parameter int TRAVEL_TICKS = DEF_TRAVEL_TICKS,
  parameter int DWELL_TICKS  = DEF_DWELL_TICKS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] req,
  output logic                  moving_up,
  output logic                  moving_down,
  output logic                  floor_reached,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  busy
);

  state_t                  state_q, state_d;
  dir_t                    dir_q, dir_d;
  logic [FLOOR_W-1:0]      floor_q, floor_d, step_floor;
  logic [NUM_FLOORS-1:0]   pending_q, pending_d, req_eff, clr_mask, above, below;
  logic                    moving_up_q, moving_down_q, floor_reached_q, busy_q;
  logic                    travel_en, travel_done, dwell_en, dwell_done;

  assign travel_en = (state_q == MOVE_UP) || (state_q == MOVE_DOWN);
  assign dwell_en  = (state_q == DWELL);

  tick_timer #(.MAX(TRAVEL_TICKS)) u_travel (
    .clk(clk), .rst_n(rst_n), .clr(!travel_en), .en(travel_en), .done(travel_done)
  );

  tick_timer #(.MAX(DWELL_TICKS)) u_dwell (
    .clk(clk), .rst_n(rst_n), .clr(!dwell_en), .en(dwell_en), .done(dwell_done)
  );

  always_comb begin
    above = '0;
    below = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      above[i] = pending_q[i] && (i > int'(floor_q));
      below[i] = pending_q[i] && (i < int'(floor_q));
    end
  end

  assign step_floor = (state_q == MOVE_UP) ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    floor_d  = floor_q;
    clr_mask = '0;
    case (state_q)
      IDLE: begin
        if (pending_q[floor_q]) begin
          state_d           = DWELL;
          clr_mask[floor_q] = 1'b1;
        end else if (|above) begin
          state_d = MOVE_UP;
          dir_d   = DIR_UP;
        end else if (|below) begin
          state_d = MOVE_DOWN;
          dir_d   = DIR_DOWN;
        end
      end
      MOVE_UP, MOVE_DOWN: begin
        if (travel_done) begin
          floor_d = step_floor;
          if (pending_q[step_floor]) begin
            state_d              = DWELL;
            clr_mask[step_floor] = 1'b1;
          end
        end
      end
      DWELL: begin
        // Keep sweeping the current direction while targets remain ahead of the car.
        if (dwell_done) begin
          if (dir_q == DIR_UP) begin
            if (|above)      state_d = MOVE_UP;
            else if (|below) begin state_d = MOVE_DOWN; dir_d = DIR_DOWN; end
            else             state_d = IDLE;
          end else begin
            if (|below)      state_d = MOVE_DOWN;
            else if (|above) begin state_d = MOVE_UP; dir_d = DIR_UP; end
            else             state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_eff = req;
    if (state_q == DWELL) req_eff[floor_q] = 1'b0;
    pending_d = (pending_q | req_eff) & ~clr_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      dir_q           <= DIR_UP;
      floor_q         <= '0;
      pending_q       <= '0;
      moving_up_q     <= 1'b0;
      moving_down_q   <= 1'b0;
      floor_reached_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      dir_q           <= dir_d;
      floor_q         <= floor_d;
      pending_q       <= pending_d;
      moving_up_q     <= (state_d == MOVE_UP);
      moving_down_q   <= (state_d == MOVE_DOWN);
      floor_reached_q <= (state_d == DWELL);
      busy_q          <= (state_d != IDLE);
    end
  end

  always @(posedge clk) begin
    if (rst_n && travel_done) begin
      assert (!((state_q == MOVE_UP)   && (floor_q == FLOOR_W'(NUM_FLOORS - 1))));
      assert (!((state_q == MOVE_DOWN) && (floor_q == '0)));
    end
  end

  assign moving_up     = moving_up_q;
  assign moving_down   = moving_down_q;
  assign floor_reached = floor_reached_q;
  assign current_floor = floor_q;
  assign pending       = pending_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed table-driven bench for elevator_scheduler with short travel and dwell times.
module tb_elevator_scheduler;
  import elevator_pkg::*;

  localparam int NF = 8;
  localparam int FW = 3;
  localparam int TT = 4;
  localparam int DT = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NF-1:0] req = '0;
  logic          moving_up, moving_down, floor_reached, busy;
  logic [FW-1:0] current_floor;
  logic [NF-1:0] pending;

  elevator_scheduler #(
    .NUM_FLOORS(NF), .FLOOR_W(FW), .TRAVEL_TICKS(TT), .DWELL_TICKS(DT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .moving_up(moving_up), .moving_down(moving_down), .floor_reached(floor_reached),
    .current_floor(current_floor), .pending(pending), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic [NF-1:0] req;
    int            rep;
    logic          mu, md, fr;
    logic [FW-1:0] cf;
    logic [NF-1:0] pend;
    logic          bsy;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input logic rst, input logic [NF-1:0] r, input int rep,
                     input logic mu, input logic md, input logic fr,
                     input logic [FW-1:0] cf, input logic [NF-1:0] pend, input logic bsy);
    vec_t v;
    v.rst = rst; v.req = r; v.rep = rep; v.mu = mu; v.md = md; v.fr = fr;
    v.cf = cf; v.pend = pend; v.bsy = bsy;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic mu, input logic md, input logic fr,
                       input logic [FW-1:0] cf, input logic [NF-1:0] pend, input logic bsy);
    n_vec++;
    if ({moving_up, moving_down, floor_reached, current_floor, pending, busy} !==
        {mu, md, fr, cf, pend, bsy}) begin
      n_bad++;
      $display("FAIL %s: got up=%b dn=%b fr=%b floor=%0d pend=%h busy=%b, want up=%b dn=%b fr=%b floor=%0d pend=%h busy=%b",
               name, moving_up, moving_down, floor_reached, current_floor, pending, busy,
               mu, md, fr, cf, pend, bsy);
    end
  endtask

  task automatic do_reset();
    req = '0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [NF-1:0] m;
    logic          found;

    // 1: single up request to floor 3
    add(1, 8'h08, 1, 0, 0, 0, 0, 8'h08, 0);
    add(0, 8'h00, 4, 1, 0, 0, 0, 8'h08, 1);
    add(0, 8'h00, 4, 1, 0, 0, 1, 8'h08, 1);
    add(0, 8'h00, 4, 1, 0, 0, 2, 8'h08, 1);
    add(0, 8'h00, 6, 0, 0, 1, 3, 8'h00, 1);
    add(0, 8'h00, 2, 0, 0, 0, 3, 8'h00, 0);
    // 2: request at the current floor goes straight to dwell
    add(1, 8'h01, 1, 0, 0, 0, 0, 8'h01, 0);
    add(0, 8'h00, 6, 0, 0, 1, 0, 8'h00, 1);
    add(0, 8'h00, 2, 0, 0, 0, 0, 8'h00, 0);
    // 5: re-request of the dwelling floor is ignored
    add(1, 8'h04, 1, 0, 0, 0, 0, 8'h04, 0);
    add(0, 8'h00, 4, 1, 0, 0, 0, 8'h04, 1);
    add(0, 8'h00, 4, 1, 0, 0, 1, 8'h04, 1);
    add(0, 8'h00, 2, 0, 0, 1, 2, 8'h00, 1);
    add(0, 8'h04, 4, 0, 0, 1, 2, 8'h00, 1);
    add(0, 8'h00, 2, 0, 0, 0, 2, 8'h00, 0);
    // 6: every floor above 0, consecutive stops
    add(1, 8'hFE, 1, 0, 0, 0, 0, 8'hFE, 0);
    for (int f = 1; f < NF; f++) begin
      m = 8'hFF; m = m << f;
      add(0, 8'h00, 4, 1, 0, 0, FW'(f - 1), m, 1);
      m = m << 1;
      add(0, 8'h00, 6, 0, 0, 1, FW'(f), m, 1);
    end
    add(0, 8'h00, 2, 0, 0, 0, 7, 8'h00, 0);
    // 3: mid-travel requests ahead and behind the car
    add(1, 8'h40, 1, 0, 0, 0, 0, 8'h40, 0);
    add(0, 8'h00, 4, 1, 0, 0, 0, 8'h40, 1);
    add(0, 8'h00, 4, 1, 0, 0, 1, 8'h40, 1);
    add(0, 8'h00, 4, 1, 0, 0, 2, 8'h40, 1);
    add(0, 8'h00, 1, 1, 0, 0, 3, 8'h40, 1);
    add(0, 8'h22, 1, 1, 0, 0, 3, 8'h62, 1);
    add(0, 8'h00, 2, 1, 0, 0, 3, 8'h62, 1);
    add(0, 8'h00, 4, 1, 0, 0, 4, 8'h62, 1);
    add(0, 8'h00, 6, 0, 0, 1, 5, 8'h42, 1);
    add(0, 8'h00, 4, 1, 0, 0, 5, 8'h42, 1);
    add(0, 8'h00, 6, 0, 0, 1, 6, 8'h02, 1);
    add(0, 8'h00, 4, 0, 1, 0, 6, 8'h02, 1);
    add(0, 8'h00, 4, 0, 1, 0, 5, 8'h02, 1);
    add(0, 8'h00, 4, 0, 1, 0, 4, 8'h02, 1);
    add(0, 8'h00, 4, 0, 1, 0, 3, 8'h02, 1);
    add(0, 8'h00, 4, 0, 1, 0, 2, 8'h02, 1);
    add(0, 8'h00, 6, 0, 0, 1, 1, 8'h00, 1);
    add(0, 8'h00, 2, 0, 0, 0, 1, 8'h00, 0);

    do_reset();
    #1;
    check("reset_state", 0, 0, 0, 0, 8'h00, 0);

    foreach (vecs[k]) begin
      if (vecs[k].rst) do_reset();
      for (int c = 0; c < vecs[k].rep; c++) begin
        @(negedge clk);
        req = (c == 0) ? vecs[k].req : '0;
        @(posedge clk);
        #1;
        check($sformatf("vec%0d.%0d", k, c), vecs[k].mu, vecs[k].md, vecs[k].fr,
              vecs[k].cf, vecs[k].pend, vecs[k].bsy);
      end
    end
    req = '0;

    n_vec++;
    if (dut.dir_q !== DIR_DOWN) begin
      n_bad++;
      $display("FAIL dir_after_reversal: got %b, want %b", dut.dir_q, DIR_DOWN);
    end

    // 4: asynchronous reset while travelling past floor 4
    do_reset();
    @(negedge clk);
    req = 8'h80;
    @(negedge clk);
    req = '0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk);
      #1;
      if (current_floor == 3'd4) found = 1'b1;
    end
    n_vec++;
    if (!found) begin
      n_bad++;
      $display("FAIL reach_floor4: got floor=%0d after 100 cycles, want 4", current_floor);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 0, 0, 0, 0, 8'h00, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("no_resume", 0, 0, 0, 0, 8'h00, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
